// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two
// requesters. Operands are registered into the ALU, held for SETTLE cycles,
// then the result/zero flag is captured for the owner with a one-cycle done pulse.
module alu_share_arbiter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  // requester 0
  input  logic             r0_req,
  input  logic [2:0]       r0_ctl,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  output logic             r0_ack,
  output logic             r0_done,
  output logic [WIDTH-1:0] r0_result,
  output logic             r0_zero,
  // requester 1
  input  logic             r1_req,
  input  logic [2:0]       r1_ctl,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  output logic             r1_ack,
  output logic             r1_done,
  output logic [WIDTH-1:0] r1_result,
  output logic             r1_zero,
  // shared alu
  output logic [2:0]       alu_ctl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             busy
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned CTL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CTL_W-1:0]   alu_ctl_q, alu_ctl_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [WIDTH-1:0]   alu_b_q, alu_b_d;
  logic               r0_ack_q, r0_ack_d;
  logic               r1_ack_q, r1_ack_d;
  logic               r0_done_q, r0_done_d;
  logic               r1_done_q, r1_done_d;
  logic [WIDTH-1:0]   r0_result_q, r0_result_d;
  logic [WIDTH-1:0]   r1_result_q, r1_result_d;
  logic               r0_zero_q, r0_zero_d;
  logic               r1_zero_q, r1_zero_d;
  logic               busy_q, busy_d;

  logic               grant_v;
  logic               grant_id;

  // Arbitration: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant_v  = r0_req | r1_req;
    grant_id = (r0_req && r1_req) ? ~last_grant_q : r1_req;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    alu_ctl_d    = alu_ctl_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    r0_ack_d     = 1'b0;
    r1_ack_d     = 1'b0;
    r0_done_d    = 1'b0;
    r1_done_d    = 1'b0;
    r0_result_d  = r0_result_q;
    r1_result_d  = r1_result_q;
    r0_zero_d    = r0_zero_q;
    r1_zero_d    = r1_zero_q;

    case (state_q)
      IDLE: begin
        if (grant_v) begin
          alu_ctl_d    = grant_id ? r1_ctl : r0_ctl;
          alu_a_d      = grant_id ? r1_a   : r0_a;
          alu_b_d      = grant_id ? r1_b   : r0_b;
          owner_d      = grant_id;
          last_grant_d = grant_id;
          r0_ack_d     = ~grant_id;
          r1_ack_d     = grant_id;
          cnt_d        = CNT_W'(SETTLE - 1);
          state_d      = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (owner_q) begin
            r1_result_d = alu_out;
            r1_zero_d   = alu_zero;
            r1_done_d   = 1'b1;
          end else begin
            r0_result_d = alu_out;
            r0_zero_d   = alu_zero;
            r0_done_d   = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any op in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      alu_ctl_q    <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      r0_ack_q     <= 1'b0;
      r1_ack_q     <= 1'b0;
      r0_done_q    <= 1'b0;
      r1_done_q    <= 1'b0;
      r0_result_q  <= '0;
      r1_result_q  <= '0;
      r0_zero_q    <= 1'b0;
      r1_zero_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      alu_ctl_q    <= alu_ctl_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      r0_ack_q     <= r0_ack_d;
      r1_ack_q     <= r1_ack_d;
      r0_done_q    <= r0_done_d;
      r1_done_q    <= r1_done_d;
      r0_result_q  <= r0_result_d;
      r1_result_q  <= r1_result_d;
      r0_zero_q    <= r0_zero_d;
      r1_zero_q    <= r1_zero_d;
      busy_q       <= busy_d;
    end
  end

  assign r0_ack    = r0_ack_q;
  assign r1_ack    = r1_ack_q;
  assign r0_done   = r0_done_q;
  assign r1_done   = r1_done_q;
  assign r0_result = r0_result_q;
  assign r1_result = r1_result_q;
  assign r0_zero   = r0_zero_q;
  assign r1_zero   = r1_zero_q;
  assign alu_ctl   = alu_ctl_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: SETTLE=1 instance (d1) driven by directed ops with
// a result scoreboard, and a SETTLE=3 instance (d3) for continuous-tie timing.
module tb_alu_share_arbiter;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // d1: SETTLE = 1
  logic        d1_r0_req, d1_r0_ack, d1_r0_done, d1_r0_zero;
  logic [2:0]  d1_r0_ctl;
  logic [31:0] d1_r0_a, d1_r0_b, d1_r0_result;
  logic        d1_r1_req, d1_r1_ack, d1_r1_done, d1_r1_zero;
  logic [2:0]  d1_r1_ctl;
  logic [31:0] d1_r1_a, d1_r1_b, d1_r1_result;
  logic [2:0]  d1_alu_ctl;
  logic [31:0] d1_alu_a, d1_alu_b, d1_alu_out;
  logic        d1_alu_zero, d1_busy;

  // d3: SETTLE = 3
  logic        d3_r0_req, d3_r0_ack, d3_r0_done, d3_r0_zero;
  logic [2:0]  d3_r0_ctl;
  logic [31:0] d3_r0_a, d3_r0_b, d3_r0_result;
  logic        d3_r1_req, d3_r1_ack, d3_r1_done, d3_r1_zero;
  logic [2:0]  d3_r1_ctl;
  logic [31:0] d3_r1_a, d3_r1_b, d3_r1_result;
  logic [2:0]  d3_alu_ctl;
  logic [31:0] d3_alu_a, d3_alu_b, d3_alu_out;
  logic        d3_alu_zero, d3_busy;

  alu_share_arbiter #(.WIDTH(32), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst),
    .r0_req(d1_r0_req), .r0_ctl(d1_r0_ctl), .r0_a(d1_r0_a), .r0_b(d1_r0_b),
    .r0_ack(d1_r0_ack), .r0_done(d1_r0_done), .r0_result(d1_r0_result), .r0_zero(d1_r0_zero),
    .r1_req(d1_r1_req), .r1_ctl(d1_r1_ctl), .r1_a(d1_r1_a), .r1_b(d1_r1_b),
    .r1_ack(d1_r1_ack), .r1_done(d1_r1_done), .r1_result(d1_r1_result), .r1_zero(d1_r1_zero),
    .alu_ctl(d1_alu_ctl), .alu_a(d1_alu_a), .alu_b(d1_alu_b),
    .alu_out(d1_alu_out), .alu_zero(d1_alu_zero), .busy(d1_busy)
  );

  alu_share_arbiter #(.WIDTH(32), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst),
    .r0_req(d3_r0_req), .r0_ctl(d3_r0_ctl), .r0_a(d3_r0_a), .r0_b(d3_r0_b),
    .r0_ack(d3_r0_ack), .r0_done(d3_r0_done), .r0_result(d3_r0_result), .r0_zero(d3_r0_zero),
    .r1_req(d3_r1_req), .r1_ctl(d3_r1_ctl), .r1_a(d3_r1_a), .r1_b(d3_r1_b),
    .r1_ack(d3_r1_ack), .r1_done(d3_r1_done), .r1_result(d3_r1_result), .r1_zero(d3_r1_zero),
    .alu_ctl(d3_alu_ctl), .alu_a(d3_alu_a), .alu_b(d3_alu_b),
    .alu_out(d3_alu_out), .alu_zero(d3_alu_zero), .busy(d3_busy)
  );

  // Combinational alu behaviour; undefined codes act as signed SLT.
  function automatic logic [31:0] alu_f(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  always_comb begin
    d1_alu_out  = alu_f(d1_alu_ctl, d1_alu_a, d1_alu_b);
    d1_alu_zero = (d1_alu_out == 32'd0);
    d3_alu_out  = alu_f(d3_alu_ctl, d3_alu_a, d3_alu_b);
    d3_alu_zero = (d3_alu_out == 32'd0);
  end

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        id;
    logic [31:0] res;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] sh0, sh1;

  // Scoreboard monitor for d1: every done pops the oldest accepted op.
  always @(negedge clk) begin
    if (rst) begin
      sh0 = 32'd0;
      sh1 = 32'd0;
    end else begin
      if (d1_r0_done && d1_r1_done) chk("two_dones", 32'd1, 32'd0);
      if (d1_r0_done || d1_r1_done) begin
        logic id;
        exp_t e;
        id = d1_r1_done;
        n_done++;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("done_id", 32'(id), 32'(e.id));
          if (!id) begin
            chk("r0_result", d1_r0_result, e.res);
            chk("r0_zero", 32'(d1_r0_zero), 32'(e.res == 32'd0));
            chk("r1_result_held", d1_r1_result, sh1);
            sh0 = e.res;
          end else begin
            chk("r1_result", d1_r1_result, e.res);
            chk("r1_zero", 32'(d1_r1_zero), 32'(e.res == 32'd0));
            chk("r0_result_held", d1_r0_result, sh0);
            sh1 = e.res;
          end
        end
      end
    end
  end

  int first, lat;

  // Drive one or both requesters on d1; drop each req once its ack is seen.
  task automatic issue(input logic u0, input logic [2:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] e0,
                       input logic u1, input logic [2:0] c1, input logic [31:0] a1, input logic [31:0] b1,
                       input logic [31:0] e1,
                       output int first_id, output int latency);
    logic p0, p1;
    p0 = u0; p1 = u1; first_id = -1; latency = 0;
    d1_r0_req = u0; d1_r0_ctl = c0; d1_r0_a = a0; d1_r0_b = b0;
    d1_r1_req = u1; d1_r1_ctl = c1; d1_r1_a = a1; d1_r1_b = b1;
    for (int i = 0; i < 40 && (p0 || p1); i++) begin
      @(posedge clk); #1;
      if (d1_r0_ack && d1_r1_ack) chk("two_acks", 32'd1, 32'd0);
      if (d1_r0_ack) begin
        chk("r0_ack_expected", 32'(p0), 32'd1);
        p0 = 1'b0; d1_r0_req = 1'b0;
        sb.push_back('{id: 1'b0, res: e0});
        if (first_id < 0) begin first_id = 0; latency = i + 1; end
      end
      if (d1_r1_ack) begin
        chk("r1_ack_expected", 32'(p1), 32'd1);
        p1 = 1'b0; d1_r1_req = 1'b0;
        sb.push_back('{id: 1'b1, res: e1});
        if (first_id < 0) begin first_id = 1; latency = i + 1; end
      end
    end
    if (p0 || p1) chk("ack_timeout", 32'({p1, p0}), 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  // Continuous tie on d3: alternation, ack-to-done distance, one idle cycle between ops.
  task automatic test5();
    int prev_id, ack_cyc, done_cyc, acks;
    prev_id = -1; ack_cyc = 0; done_cyc = -1; acks = 0;
    d3_r0_ctl = OP_ADD; d3_r0_a = 32'd1;  d3_r0_b = 32'd2;
    d3_r1_ctl = OP_SUB; d3_r1_a = 32'd10; d3_r1_b = 32'd4;
    d3_r0_req = 1'b1; d3_r1_req = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      if (d3_r0_ack || d3_r1_ack) begin
        int id;
        id = d3_r1_ack ? 1 : 0;
        chk("t5_alternate", 32'(id), (prev_id < 0) ? 32'd0 : 32'(1 - prev_id));
        if (done_cyc >= 0) chk("t5_idle_gap", 32'(cyc - done_cyc), 32'd1);
        chk("t5_busy_at_ack", 32'(d3_busy), 32'd1);
        prev_id = id; ack_cyc = cyc; acks++;
      end
      if (d3_r0_done || d3_r1_done) begin
        chk("t5_done_id", 32'(d3_r1_done), 32'(prev_id));
        chk("t5_ack_to_done", 32'(cyc - ack_cyc), 32'd3);
        chk("t5_busy_at_done", 32'(d3_busy), 32'd0);
        chk("t5_result", d3_r1_done ? d3_r1_result : d3_r0_result, d3_r1_done ? 32'd6 : 32'd3);
        done_cyc = cyc;
      end
    end
    d3_r0_req = 1'b0; d3_r1_req = 1'b0;
    chk("t5_ack_count", 32'(acks >= 8), 32'd1);
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    rst = 1'b1;
    d1_r0_req = 0; d1_r0_ctl = 0; d1_r0_a = 0; d1_r0_b = 0;
    d1_r1_req = 0; d1_r1_ctl = 0; d1_r1_a = 0; d1_r1_b = 0;
    d3_r0_req = 0; d3_r0_ctl = 0; d3_r0_a = 0; d3_r0_b = 0;
    d3_r1_req = 0; d3_r1_ctl = 0; d3_r1_a = 0; d3_r1_b = 0;
    #12;
    chk("rst_acks_dones", 32'({d1_r0_ack, d1_r1_ack, d1_r0_done, d1_r1_done}), 32'd0);
    chk("rst_results", d1_r0_result | d1_r1_result, 32'd0);
    chk("rst_zeros", 32'({d1_r0_zero, d1_r1_zero}), 32'd0);
    chk("rst_alu", d1_alu_a | d1_alu_b | 32'(d1_alu_ctl), 32'd0);
    chk("rst_busy", 32'({d1_busy, d3_busy}), 32'd0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // 1: single ADD, ack one edge after request, done one edge later
    issue(1, OP_ADD, 32'd5, 32'd7, 32'd12, 0, OP_AND, 0, 0, 0, first, lat);
    chk("t1_first", 32'(first), 32'd0);
    chk("t1_ack_latency", 32'(lat), 32'd1);
    @(posedge clk); #1;
    chk("t1_done", 32'({d1_r0_done, d1_r0_ack}), 32'b10);
    chk("t1_result", d1_r0_result, 32'd12);
    chk("t1_zero", 32'(d1_r0_zero), 32'd0);
    @(posedge clk); #1;
    chk("t1_done_pulse", 32'(d1_r0_done), 32'd0);
    drain();

    // 2: tie with r0 last granted at reset-equivalent state? r0 was granted by test 1, so r1 wins this tie
    issue(1, OP_SUB, 32'd9, 32'd9, 32'd0, 1, OP_AND, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, first, lat);
    chk("t2_tie_after_r0", 32'(first), 32'd1);
    drain();
    // r0 served last in the tie above, so the next tie goes to r1 again after an r0-only op
    issue(1, OP_ADD, 32'd1, 32'd1, 32'd2, 0, OP_AND, 0, 0, 0, first, lat);
    drain();
    issue(1, OP_AND, 32'hFFFF0000, 32'h0000FFFF, 32'd0, 1, OP_ADD, 32'd3, 32'd4, 32'd7, first, lat);
    chk("t2_tie_repeat", 32'(first), 32'd1);
    drain();

    // 3: SLT through r1, signed compare
    issue(0, OP_AND, 0, 0, 0, 1, OP_SLT, 32'd3, 32'd5, 32'd1, first, lat);
    drain();
    issue(0, OP_AND, 0, 0, 0, 1, OP_SLT, 32'd5, 32'd3, 32'd0, first, lat);
    drain();
    chk("t3_zero", 32'(d1_r1_zero), 32'd1);
    issue(0, OP_AND, 0, 0, 0, 1, OP_SLT, 32'hFFFFFFFF, 32'd1, 32'd1, first, lat);
    drain();
    chk("t3_neg_lt", d1_r1_result, 32'd1);

    // 6: r0 OR result must survive a following r1 op
    issue(1, OP_OR, 32'h80000000, 32'd1, 32'h80000001, 0, OP_AND, 0, 0, 0, first, lat);
    drain();
    issue(0, OP_AND, 0, 0, 0, 1, OP_ADD, 32'd20, 32'd22, 32'd42, first, lat);
    drain();
    chk("t6_r0_held", d1_r0_result, 32'h80000001);

    // 4: reset pulse one cycle into EXEC aborts the op
    d1_r0_req = 1'b1; d1_r0_ctl = OP_ADD; d1_r0_a = 32'd1; d1_r0_b = 32'd1;
    @(posedge clk); #1;
    chk("t4_ack", 32'(d1_r0_ack), 32'd1);
    d1_r0_req = 1'b0;
    dc = n_done;
    rst = 1'b1;
    #1;
    chk("t4_flags", 32'({d1_r0_ack, d1_r1_ack, d1_r0_done, d1_r1_done, d1_busy}), 32'd0);
    chk("t4_results", d1_r0_result | d1_r1_result, 32'd0);
    chk("t4_alu", d1_alu_a | d1_alu_b | 32'(d1_alu_ctl), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t4_no_done", 32'(n_done - dc), 32'd0);
    issue(1, OP_ADD, 32'd2, 32'd2, 32'd4, 1, OP_ADD, 32'd3, 32'd3, 32'd6, first, lat);
    chk("t4_tie_r0", 32'(first), 32'd0);
    drain();

    // 5: SETTLE=3 continuous tie
    test5();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
